// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds default widths, the requester ID encoding and the register-0 address.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DEPTH_DEF  = 2;

    // Requester identity, also the encoding of the last_grant register
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // Architectural zero register: writes are dropped, reads never hazard
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_wb_arbiter_wb_queue.sv
// wb_queue: DEPTH-entry synchronous FIFO of (address, data) writeback entries.
// Ports:
//   clk, rst (async active-low)
//   push, push_addr, push_data   enqueue one entry (caller guarantees not full)
//   pop                          dequeue the head (caller guarantees not empty)
//   count                        number of stored entries
//   head_addr, head_data         oldest entry
//   entry_valid, entry_addr      per-slot occupancy and address for hazard compare
module wb_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [ADDR_W-1:0]              push_addr,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic [CNT_W-1:0]               count,
    output logic [ADDR_W-1:0]              head_addr,
    output logic [DATA_W-1:0]              head_data,
    output logic [DEPTH-1:0]               entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr
);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Addresses are reset so hazard compare never sees stale slots
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) addr_mem[i] <= '0;
        end else if (push) begin
            addr_mem[wr_ptr] <= push_addr;
        end
    end

    // Data payload needs no reset; it is only consumed behind a valid entry
    always_ff @(posedge clk) begin
        if (push) data_mem[wr_ptr] <= push_data;
    end

    // A slot is occupied when its distance from the read pointer is below count
    always_comb begin
        entry_valid = '0;
        entry_addr  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count;
            entry_addr[i]  = addr_mem[i];
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the ALU and
// memory writeback requesters through two queues and a round-robin arbiter,
// reports read-after-write hazards and optionally bypasses the write stage.
// Optional feature macro: REGFILE_WB_BYPASS_EN (write-stage bypass onto reads).
// Ports:
//   clk, rst (async active-low)
//   alu_valid/alu_ready/alu_addr/alu_data   ALU writeback push
//   mem_valid/mem_ready/mem_addr/mem_data   load writeback push
//   rf_write_en/rf_write_addr/rf_write_data registered register file write port
//   rd1_addr, rd2_addr                      read addresses
//   rf_rd1_data, rf_rd2_data                raw register file read data
//   rd1_data, rd2_data                      read data to the pipeline
//   rd_hazard                               read hits a pending write
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    input  logic [DATA_W-1:0] rf_rd1_data,
    input  logic [DATA_W-1:0] rf_rd2_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd_hazard
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                         active;
    req_id_e                      last_grant;
    req_id_e                      last_grant_nxt;
    logic                         grant_alu;
    logic                         grant_mem;
    logic                         wr_en_nxt;
    logic [ADDR_W-1:0]            wr_addr_nxt;
    logic [DATA_W-1:0]            wr_data_nxt;

    logic                         alu_push;
    logic                         mem_push;
    logic [CNT_W-1:0]             alu_count;
    logic [CNT_W-1:0]             mem_count;
    logic [ADDR_W-1:0]            alu_head_addr;
    logic [ADDR_W-1:0]            mem_head_addr;
    logic [DATA_W-1:0]            alu_head_data;
    logic [DATA_W-1:0]            mem_head_data;
    logic [DEPTH-1:0]             alu_entry_valid;
    logic [DEPTH-1:0]             mem_entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] alu_entry_addr;
    logic [DEPTH-1:0][ADDR_W-1:0] mem_entry_addr;

    logic rd1_live;
    logic rd2_live;
    logic rd1_q_hit;
    logic rd2_q_hit;
    logic rd1_ws_hit;
    logic rd2_ws_hit;

    // Ready is held low during reset and asserts from the first edge after release
    assign alu_ready = active && (alu_count < CNT_W'(DEPTH));
    assign mem_ready = active && (mem_count < CNT_W'(DEPTH));
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;

    wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_alu_queue (
        .clk         (clk),
        .rst         (rst),
        .push        (alu_push),
        .push_addr   (alu_addr),
        .push_data   (alu_data),
        .pop         (grant_alu),
        .count       (alu_count),
        .head_addr   (alu_head_addr),
        .head_data   (alu_head_data),
        .entry_valid (alu_entry_valid),
        .entry_addr  (alu_entry_addr)
    );

    wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_queue (
        .clk         (clk),
        .rst         (rst),
        .push        (mem_push),
        .push_addr   (mem_addr),
        .push_data   (mem_data),
        .pop         (grant_mem),
        .count       (mem_count),
        .head_addr   (mem_head_addr),
        .head_data   (mem_head_data),
        .entry_valid (mem_entry_valid),
        .entry_addr  (mem_entry_addr)
    );

    // Round-robin grant and next write-stage contents
    always_comb begin
        grant_alu      = 1'b0;
        grant_mem      = 1'b0;
        last_grant_nxt = last_grant;
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = rf_write_addr;
        wr_data_nxt    = rf_write_data;
        if ((alu_count != '0) && ((mem_count == '0) || (last_grant == REQ_MEM))) begin
            grant_alu = 1'b1;
        end else if (mem_count != '0) begin
            grant_mem = 1'b1;
        end
        if (grant_alu) begin
            last_grant_nxt = REQ_ALU;
            wr_en_nxt      = alu_head_addr != ADDR_W'(REG_ZERO);
            wr_addr_nxt    = alu_head_addr;
            wr_data_nxt    = alu_head_data;
        end else if (grant_mem) begin
            last_grant_nxt = REQ_MEM;
            wr_en_nxt      = mem_head_addr != ADDR_W'(REG_ZERO);
            wr_addr_nxt    = mem_head_addr;
            wr_data_nxt    = mem_head_data;
        end
    end

    // Arbiter state and registered write stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active        <= 1'b0;
            last_grant    <= REQ_MEM;
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else begin
            active        <= 1'b1;
            last_grant    <= last_grant_nxt;
            rf_write_en   <= wr_en_nxt;
            rf_write_addr <= wr_addr_nxt;
            rf_write_data <= wr_data_nxt;
        end
    end

    // Compare read addresses against every occupied queue slot
    always_comb begin
        rd1_q_hit = 1'b0;
        rd2_q_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_entry_valid[i] && (alu_entry_addr[i] == rd1_addr)) rd1_q_hit = 1'b1;
            if (alu_entry_valid[i] && (alu_entry_addr[i] == rd2_addr)) rd2_q_hit = 1'b1;
            if (mem_entry_valid[i] && (mem_entry_addr[i] == rd1_addr)) rd1_q_hit = 1'b1;
            if (mem_entry_valid[i] && (mem_entry_addr[i] == rd2_addr)) rd2_q_hit = 1'b1;
        end
    end

    assign rd1_live   = rd1_addr != ADDR_W'(REG_ZERO);
    assign rd2_live   = rd2_addr != ADDR_W'(REG_ZERO);
    assign rd1_ws_hit = rf_write_en && (rf_write_addr == rd1_addr);
    assign rd2_ws_hit = rf_write_en && (rf_write_addr == rd2_addr);

`ifdef REGFILE_WB_BYPASS_EN
    // In-flight write is forwarded, so only queued entries are hazards
    assign rd_hazard = (rd1_live && rd1_q_hit) || (rd2_live && rd2_q_hit);
    assign rd1_data  = (rd1_live && rd1_ws_hit) ? rf_write_data : rf_rd1_data;
    assign rd2_data  = (rd2_live && rd2_ws_hit) ? rf_write_data : rf_rd2_data;
`else
    assign rd_hazard = (rd1_live && (rd1_q_hit || rd1_ws_hit)) ||
                       (rd2_live && (rd2_q_hit || rd2_ws_hit));
    assign rd1_data  = rf_rd1_data;
    assign rd2_data  = rf_rd2_data;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 64-bit register file between the ALU and memory writeback requesters. Each requester pushes (address, data) pairs through a valid/ready handshake into its own small queue. A round-robin arbiter drains one entry per cycle into a registered write stage that drives the register file write port. The block also reports read-after-write hazards to the pipeline controller and, optionally, bypasses the in-flight write onto the two read ports.

## Interface
Parameters:
- DATA_W, 64, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, entries per requester queue (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid / alu_ready  in / out  1  ALU writeback handshake
- alu_addr / alu_data  in  ADDR_W / DATA_W  ALU destination register and value
- mem_valid / mem_ready  in / out  1  memory writeback handshake
- mem_addr / mem_data  in  ADDR_W / DATA_W  load destination register and value
- rf_write_en  out  1  register file write enable
- rf_write_addr / rf_write_data  out  ADDR_W / DATA_W  register file write address and data
- rd1_addr, rd2_addr  in  ADDR_W  read addresses, also wired to the register file
- rf_rd1_data, rf_rd2_data  in  DATA_W  raw register file read data
- rd1_data, rd2_data  out  DATA_W  read data delivered to the pipeline
- rd_hazard  out  1  a read address matches an unwritten pending write

## Operation
- Push: an entry is accepted on a rising edge when valid && ready. ready = (queue count < DEPTH). ready does not depend on a same-cycle pop, so a full queue accepts nothing until the cycle after it drains.
- Arbitration:
  - Only one queue non-empty: that queue is granted.
  - Both non-empty: grant the queue not granted last. The last_grant register updates only on a grant.
  - Upstream guarantees no same-address write-after-write ordering across the two requesters. Order within one queue is strictly FIFO.
- Write stage: the granted head is popped and registered into rf_write_en/addr/data. If no queue is granted, rf_write_en = 0 and addr/data hold their previous values.
- Register 0: entries with addr 0 are accepted and popped, but rf_write_en stays 0 for them.
- rd_hazard: 1 when a nonzero rd1_addr or rd2_addr equals the address of any valid queue entry, or of the write stage while rf_write_en = 1. When bypass is compiled in, write-stage matches are excluded (see Configuration).
- Address 0 never raises a hazard and never bypasses.

## Timing
- Reset (rst low, asynchronous):
  - Both queues empty.
  - last_grant = MEM, so ALU wins the first tie.
  - rf_write_en = 0, rf_write_addr = 0, rf_write_data = 0.
  - alu_ready = mem_ready = 0 while rst is low; both are 1 from the first edge after release.
- Latency: an entry accepted at edge N into an empty queue with no contention drives rf_write_en from edge N+1 to edge N+2. The register file commits it at edge N+2.
- Throughput: 1 write per cycle. Under full contention each requester gets 1 write every 2 cycles.
- Simultaneous push and pop on a non-full queue: both take effect, and the count is unchanged.
- Reset asserted mid-operation discards all queued and in-flight writes. No partial write reaches the register file after rst falls.
- rd_hazard and rd1/rd2_data are combinational from the read addresses and registered state.

## Configuration
- Macro REGFILE_WB_BYPASS_EN.
- Defined:
  - If rf_write_en = 1 and rdX_addr == rf_write_addr != 0, then rdX_data = rf_write_data. Otherwise rdX_data = rf_rdX_data.
  - A write-stage match does not raise rd_hazard; only queue entries do.
- Undefined:
  - rdX_data = rf_rdX_data always.
  - A write-stage match raises rd_hazard.

## Structure
- Shared package: DATA_W/ADDR_W defaults, the requester ID encoding (ALU = 0, MEM = 1), and the register-0 address constant.
- One sub-module: wb_queue, a DEPTH-entry synchronous FIFO that exposes count, head, and per-entry valid and address for hazard compare. It is instantiated twice.

## Test plan
- Single ALU write: alu_addr = 16, alu_data = 0x8FA40000_00000000 accepted at edge N → rf_write_en = 1 with addr 16 and that data at edge N+1; read of 16 returns it after edge N+2.
- Contention: alu_valid and mem_valid held high with distinct addresses 1..8 → write port alternates ALU, MEM, ALU… starting with ALU after reset; no loss and per-queue order preserved.
- Backpressure: mem_valid held with no grants (ALU queue kept busy) → mem_ready = 0 after DEPTH = 2 accepts; a third entry is not taken until the cycle after a pop.
- Register 0: ALU write to addr 0 with data 0xFFFF… → popped, rf_write_en stays 0, rd_hazard = 0 for read addr 0.
- Hazard and bypass: queue a write to 5, drive rd1_addr = 5 → rd_hazard = 1 while queued. With REGFILE_WB_BYPASS_EN in the write-stage cycle: rd1_data = new value and rd_hazard = 0. Without the macro: rd1_data = old value and rd_hazard = 1.
- Reset mid-flight: drop rst with both queues full → all outputs reach their reset values immediately; no rf_write_en pulse after release until a new push.
